imm_packer: RTL and testbench

- Inverse of the immediate generator: takes a signed 32-bit immediate plus an extension-op code and scatters it into the RISC-V immediate bit positions of a 32-bit instruction template.
- Performs a range and alignment check on the immediate, and counts failed checks.
- Used by the debug/test-program injector to build instructions on the fly.
- Ready/valid on both sides, 1-cycle latency, full throughput via a skid buffer.

---
 rtl/imm_packer.sv | 181 ++++++++++++++++++
 tb/tb_imm_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// ============================================================================
// Module     : imm_packer
// Description: Scatters a signed immediate into the RISC-V immediate field of
//              an instruction template, with range/alignment checking and a
//              saturating error counter. Optional macro:
//              IMM_PACKER_ROUNDTRIP_CHECK_EN (decode-back consistency check).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_packer #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_ext_op,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_tmpl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
  output logic                 rt_mismatch,
`endif
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [1:0] c_OP_I = 2'b00;
  localparam logic [1:0] c_OP_U = 2'b01;
  localparam logic [1:0] c_OP_B = 2'b10;
  localparam logic [1:0] c_OP_J = 2'b11;

  logic [31:0] w_inst;
  logic        w_err;
  logic        w_err_all;
  logic        w_acc;
  logic        w_load_main;

  // Packing plus range/alignment check; out-of-range values are still packed truncated.
  always_comb begin
    w_inst = in_tmpl;
    w_err  = 1'b0;
    if (in_ext_op[2]) begin
      w_inst[31:25] = in_imm[11:5];
      w_inst[11:7]  = in_imm[4:0];
      w_err         = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
    end else begin
      case (in_ext_op[1:0])
        c_OP_I: begin
          w_inst[31:20] = in_imm[11:0];
          w_err         = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
        end
        c_OP_U: begin
          w_inst[31:12] = in_imm[31:12];
          w_err         = |in_imm[11:0];
        end
        c_OP_B: begin
          w_inst[31]    = in_imm[12];
          w_inst[30:25] = in_imm[10:5];
          w_inst[11:8]  = in_imm[4:1];
          w_inst[7]     = in_imm[11];
          w_err         = ~((&in_imm[31:12]) | ~(|in_imm[31:12])) | in_imm[0];
        end
        default: begin
          w_inst[31]    = in_imm[20];
          w_inst[30:21] = in_imm[10:1];
          w_inst[20]    = in_imm[11];
          w_inst[19:12] = in_imm[19:12];
          w_err         = ~((&in_imm[31:20]) | ~(|in_imm[31:20])) | in_imm[0];
        end
      endcase
    end
  end

`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
  logic [31:0] w_dec;
  logic        w_rt_mm;
  logic        r_main_mm;
  logic        r_skid_mm;

  // Re-extract the immediate exactly as the immediate generator would.
  always_comb begin
    w_dec = 32'd0;
    if (in_ext_op[2]) begin
      w_dec = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    end else begin
      case (in_ext_op[1:0])
        c_OP_I:  w_dec = {{20{w_inst[31]}}, w_inst[31:20]};
        c_OP_U:  w_dec = {w_inst[31:12], 12'd0};
        c_OP_B:  w_dec = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                          w_inst[11:8], 1'b0};
        default: w_dec = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                          w_inst[30:21], 1'b0};
      endcase
    end
  end

  assign w_rt_mm   = ~w_err & (w_dec != in_imm);
  assign w_err_all = w_err | w_rt_mm;
`else
  assign w_err_all = w_err;
`endif

  logic                 r_main_valid;
  logic [31:0]          r_main_inst;
  logic                 r_main_err;
  logic                 r_skid_valid;
  logic [31:0]          r_skid_inst;
  logic                 r_skid_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign in_ready    = ~r_skid_valid;
  assign w_acc       = in_valid & ~r_skid_valid;
  assign w_load_main = ~r_main_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_inst  <= 32'd0;
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_inst  <= 32'd0;
      r_skid_err   <= 1'b0;
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
      r_main_mm    <= 1'b0;
      r_skid_mm    <= 1'b0;
`endif
    end else if (w_load_main) begin
      // Skid has priority so ordering holds; it cannot coexist with an accept.
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_inst  <= r_skid_inst;
        r_main_err   <= r_skid_err;
        r_skid_valid <= 1'b0;
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
        r_main_mm    <= r_skid_mm;
`endif
      end else begin
        r_main_valid <= w_acc;
        if (w_acc) begin
          r_main_inst <= w_inst;
          r_main_err  <= w_err;
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
          r_main_mm   <= w_rt_mm;
`endif
        end
      end
    end else if (w_acc) begin
      r_skid_valid <= 1'b1;
      r_skid_inst  <= w_inst;
      r_skid_err   <= w_err;
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
      r_skid_mm    <= w_rt_mm;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_acc && w_err_all && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid = r_main_valid;
  assign out_inst  = r_main_inst;
  assign err_cnt   = r_err_cnt;
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
  assign out_err     = r_main_err | r_main_mm;
  assign rt_mismatch = r_main_mm;
`else
  assign out_err = r_main_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_packer.sv
// ============================================================================
// Module     : tb_imm_packer
// Description: Self-checking bench for imm_packer: directed literal cases plus
//              randomized traffic against a queue-based reference model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_packer;

  localparam int ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [2:0]           in_ext_op = 3'd0;
  logic [31:0]          in_imm = 32'd0;
  logic [31:0]          in_tmpl = 32'd0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [31:0]          out_inst;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_cnt;
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
  logic                 rt_mismatch;
`endif

  int n_checks = 0;
  int n_errors = 0;

  imm_packer #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ext_op  (in_ext_op),
    .in_imm     (in_imm),
    .in_tmpl    (in_tmpl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_err    (out_err),
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
    .rt_mismatch(rt_mismatch),
`endif
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {err, inst} computed from signed-range arithmetic and field rules.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] imm,
                                        input logic [31:0] tmpl);
    logic [31:0] t = tmpl;
    int          si = $signed(imm);
    logic        e;
    if (op[2]) begin
      t[31:25] = imm[11:5];
      t[11:7]  = imm[4:0];
      e = (si < -2048) || (si > 2047);
    end else if (op[1:0] == 2'd0) begin
      t[31:20] = imm[11:0];
      e = (si < -2048) || (si > 2047);
    end else if (op[1:0] == 2'd1) begin
      t[31:12] = imm[31:12];
      e = (imm % 32'd4096) != 32'd0;
    end else if (op[1:0] == 2'd2) begin
      t[31] = imm[12]; t[30:25] = imm[10:5]; t[11:8] = imm[4:1]; t[7] = imm[11];
      e = (si < -4096) || (si > 4095) || (si % 2 != 0);
    end else begin
      t[31] = imm[20]; t[30:21] = imm[10:1]; t[20] = imm[11]; t[19:12] = imm[19:12];
      e = (si < -(1 << 20)) || (si > (1 << 20) - 1) || (si % 2 != 0);
    end
    return {e, t};
  endfunction

  // Compare process: outputs are checked at the falling edge, then the model
  // advances with the handshakes that the next rising edge will take.
  logic [32:0] q[$];
  int          m_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    end else begin
      logic acc, drn;
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("err_cnt", {24'd0, err_cnt}, m_cnt);
      if (q.size() > 0) begin
        chk("out_inst", out_inst, q[0][31:0]);
        chk("out_err", {31'd0, out_err}, {31'd0, q[0][32]});
      end
`ifdef IMM_PACKER_ROUNDTRIP_CHECK_EN
      chk("rt_mismatch", {31'd0, rt_mismatch}, 32'd0);
`endif
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) begin
        logic [32:0] m;
        m = model(in_ext_op, in_imm, in_tmpl);
        q.push_back(m);
        if (m[32] && m_cnt < (1 << ERR_CNT_W) - 1) m_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] tmpl);
    cyc();
    in_valid = 1'b1; in_ext_op = op; in_imm = imm; in_tmpl = tmpl;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    push(3'b000, 32'hFFFF_FFFF, 32'h0000_0013);
    chk("lit_I_inst", out_inst, 32'hFFF0_0013);
    chk("lit_I_err", {31'd0, out_err}, 32'd0);
    push(3'b001, 32'h1234_5000, 32'h0000_0037);
    chk("lit_U_inst", out_inst, 32'h1234_5037);
    chk("lit_U_err", {31'd0, out_err}, 32'd0);
    push(3'b001, 32'h1234_5001, 32'h0000_0037);
    chk("lit_U_bad_err", {31'd0, out_err}, 32'd1);
    chk("lit_U_bad_cnt", {24'd0, err_cnt}, 32'd1);
    push(3'b010, 32'd8, 32'h0000_0063);
    chk("lit_B_inst", out_inst, 32'h0000_0463);
    push(3'b011, 32'hFFFF_FFFC, 32'h0000_006F);
    chk("lit_J_inst", out_inst, 32'hFFDF_F06F);
    push(3'b100, 32'd4, 32'h0000_2023);
    chk("lit_S_inst", out_inst, 32'h0000_2223);

    cyc(); rst = 1'b1; cyc(); rst = 1'b0;
    push(3'b010, 32'd9, 32'h0000_0063);
    chk("lit_B_odd_err", {31'd0, out_err}, 32'd1);
    push(3'b000, 32'd2048, 32'h0000_0013);
    chk("lit_I_range_err", {31'd0, out_err}, 32'd1);
    push(3'b011, 32'h0010_0000, 32'h0000_006F);
    chk("lit_J_range_err", {31'd0, out_err}, 32'd1);
    chk("lit_err_cnt3", {24'd0, err_cnt}, 32'd3);

    // Backpressure: three back-to-back requests into a stalled output.
    cyc(); out_ready = 1'b0;
    in_valid = 1'b1; in_ext_op = 3'b000; in_tmpl = 32'h13; in_imm = 32'd1;
    cyc(); in_imm = 32'd2;
    cyc(); in_imm = 32'd3;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("bp_stall_inst", out_inst, 32'h0010_0013);
    chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    cyc();
    chk("bp_out2", out_inst, 32'h0020_0013);
    cyc();
    chk("bp_out3", out_inst, 32'h0030_0013);
    in_valid = 1'b0;
    cyc();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with both buffers full of erroring requests.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ext_op = 3'b000; in_tmpl = 32'h13; in_imm = 32'd4096;
    cyc(); in_imm = 32'd5000;
    cyc(); in_valid = 1'b0;
    chk("full_err_cnt", {24'd0, err_cnt}, 32'd5);
    @(posedge clk); #2; rst = 1'b1; #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_cnt", {24'd0, err_cnt}, 32'd0);
    cyc(); rst = 1'b0;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) begin
      cyc();
      chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_ext_op = 3'($urandom);
      in_tmpl   = $urandom;
      case ($urandom % 4)
        0:       in_imm = $urandom;
        1:       in_imm = {{19{1'b0}}, 13'($urandom)} ^ (($urandom % 2 != 0) ? 32'hFFFF_E000 : 32'd0);
        2:       in_imm = {{10{1'b0}}, 22'($urandom)} ^ (($urandom % 2 != 0) ? 32'hFFC0_0000 : 32'd0);
        default: in_imm = $urandom & 32'hFFFF_F000 | (($urandom % 4 == 0) ? 32'd1 : 32'd0);
      endcase
    end
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
